// File: rtl/icb_master.sv
// ICB bus master: queues local requests in a FIFO and issues them one at a time on the ICB
// command/response channels, reporting each completion (or per-phase timeout) on resp_*.
module icb_master #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_read,
   input  logic [31:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wmask,
   output logic        icb_cmd_valid,
   input  logic        icb_cmd_ready,
   output logic [31:0] icb_cmd_addr,
   output logic        icb_cmd_read,
   output logic [63:0] icb_cmd_wdata,
   output logic [7:0]  icb_cmd_wmask,
   input  logic        icb_rsp_valid,
   output logic        icb_rsp_ready,
   input  logic [63:0] icb_rsp_rdata,
   input  logic        icb_rsp_err,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned EW = 1 + 32 + 64 + 8;

   typedef enum logic [1:0] {StIdle, StCmd, StRsp} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   count_q;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [EW-1:0]   cmd_q, cmd_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            resp_valid_q, resp_valid_d;
   logic [63:0]     resp_rdata_q, resp_rdata_d;
   logic            resp_err_q, resp_err_d;
   logic            push, pop, timeout;

   assign req_ready = (count_q < CW'(DEPTH));
   assign push      = req_valid && req_ready;
   assign pop       = (state_q == StIdle) && (count_q != '0);
   // Last permitted cycle of the current phase; a handshake in that cycle still wins.
   assign timeout   = (timer_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {req_read, req_addr, req_wdata, req_wmask};
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      cmd_d        = cmd_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               cmd_d   = mem_q[rptr_q];
               timer_d = '0;
               state_d = StCmd;
            end
         end
         StCmd: begin
            if (icb_cmd_ready) begin
               timer_d = '0;
               state_d = StRsp;
            end else if (timeout) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
               resp_err_d   = 1'b1;
               state_d      = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StRsp: begin
            if (icb_rsp_valid) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = cmd_q[EW-1] ? icb_rsp_rdata : 64'h0;
               resp_err_d   = icb_rsp_err;
               state_d      = StIdle;
            end else if (timeout) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
               resp_err_d   = 1'b1;
               state_d      = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         cmd_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         cmd_q        <= cmd_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask} = cmd_q;
   assign icb_cmd_valid = (state_q == StCmd);
   assign icb_rsp_ready = (state_q == StRsp);
   assign resp_valid    = resp_valid_q;
   assign resp_rdata    = resp_rdata_q;
   assign resp_err      = resp_err_q;
   assign busy          = (count_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_icb_master.sv
// Bench for icb_master: a scripted ICB slave plus a transaction-level model of the expected
// completions; directed scenarios followed by a randomized run.
module tb_icb_master;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 16;
   localparam int          BOUND   = 2000;

   typedef struct packed {
      logic        rd;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } req_t;

   typedef struct packed {
      int          cmd_delay;
      int          rsp_delay;
      logic [63:0] rdata;
      logic        err;
   } plan_t;

   typedef struct packed {
      req_t req;
      int   cmd_cycles;
      int   rsp_cycles;
      logic unstable;
   } seen_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } got_t;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_read;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
   logic [31:0] icb_cmd_addr;
   logic [63:0] icb_cmd_wdata;
   logic [7:0]  icb_cmd_wmask;
   logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
   logic [63:0] icb_rsp_rdata;
   logic        resp_valid, resp_err, busy;
   logic [63:0] resp_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   int hold_bad = 0;

   req_t  exp_q[$];
   plan_t plan_q[$];
   seen_t seen_q[$];
   got_t  got_q[$];

   icb_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
      .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
      .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
      .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

   // Slave: each transaction follows the next plan entry (command wait, response wait, data).
   seen_t cur;
   plan_t cp;
   bit    in_txn;
   initial begin
      icb_cmd_ready = 1'b0;
      icb_rsp_valid = 1'b0;
      icb_rsp_rdata = '0;
      icb_rsp_err   = 1'b0;
      in_txn        = 1'b0;
      forever begin
         @(negedge clk);
         icb_cmd_ready = 1'b0;
         icb_rsp_valid = 1'b0;
         icb_rsp_rdata = {$urandom, $urandom};
         icb_rsp_err   = 1'($urandom_range(0, 1));
         if (!rst_n) begin
            in_txn = 1'b0;
         end else if (icb_cmd_valid) begin
            if (!in_txn) begin
               in_txn = 1'b1;
               if (plan_q.size() > 0) cp = plan_q.pop_front();
               else cp = '0;
               cur.req = {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask};
               cur.cmd_cycles = 0;
               cur.rsp_cycles = 0;
               cur.unstable   = 1'b0;
            end else if (cur.req !== {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata,
                                      icb_cmd_wmask}) begin
               cur.unstable = 1'b1;
            end
            if (cur.cmd_cycles == cp.cmd_delay) icb_cmd_ready = 1'b1;
            cur.cmd_cycles++;
         end else if (icb_rsp_ready) begin
            if (cur.rsp_cycles == cp.rsp_delay) begin
               icb_rsp_valid = 1'b1;
               icb_rsp_rdata = cp.rdata;
               icb_rsp_err   = cp.err;
            end
            cur.rsp_cycles++;
         end else if (in_txn) begin
            in_txn = 1'b0;
            seen_q.push_back(cur);
         end
      end
   end

   // Completion monitor; also flags resp_rdata/resp_err changing between pulses.
   logic [63:0] last_rdata;
   logic        last_err;
   initial begin
      last_rdata = '0;
      last_err   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last_rdata = '0;
            last_err   = 1'b0;
         end else if (resp_valid) begin
            got_q.push_back({resp_rdata, resp_err});
            last_rdata = resp_rdata;
            last_err   = resp_err;
         end else if (resp_rdata !== last_rdata || resp_err !== last_err) begin
            hold_bad++;
         end
      end
   end

   function automatic got_t model_resp(input req_t r, input plan_t p);
      got_t g;
      if (p.cmd_delay >= int'(TIMEOUT) || p.rsp_delay >= int'(TIMEOUT)) begin
         g.rdata = 64'h0;
         g.err   = 1'b1;
      end else begin
         g.rdata = r.rd ? p.rdata : 64'h0;
         g.err   = p.err;
      end
      return g;
   endfunction

   function automatic plan_t mk_plan(input int cd, input int rd, input logic [63:0] d,
                                     input logic e);
      plan_t p;
      p.cmd_delay = cd;
      p.rsp_delay = rd;
      p.rdata     = d;
      p.err       = e;
      return p;
   endfunction

   function automatic req_t mk_req(input logic rd, input logic [31:0] a, input logic [63:0] d,
                                   input logic [7:0] m);
      req_t r;
      r.rd    = rd;
      r.addr  = a;
      r.wdata = d;
      r.wmask = m;
      return r;
   endfunction

   task automatic clear_q();
      exp_q.delete();
      plan_q.delete();
      seen_q.delete();
      got_q.delete();
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic push_req(input req_t r, output int stall);
      stall     = 0;
      req_valid = 1'b1;
      req_read  = r.rd;
      req_addr  = r.addr;
      req_wdata = r.wdata;
      req_wmask = r.wmask;
      while (!req_ready && stall < BOUND) begin
         @(negedge clk);
         stall++;
      end
      if (!req_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL push_accept: req_ready=%b after %0d cycles, required 1", req_ready, stall);
      end else begin
         exp_q.push_back(r);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int c = 0;
      while (busy && c < BOUND) begin
         @(negedge clk);
         c++;
      end
      if (busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: busy=%b after %0d cycles, required 0", busy, c);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [5:0] ctrl;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_read  = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      repeat (2) @(negedge clk);
      ctrl = {req_ready, icb_cmd_valid, icb_rsp_ready, resp_valid, resp_err, busy};
      n_cmp++;
      if (ctrl !== 6'b100000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b, required 100000", ctrl);
      end
      n_cmp++;
      if (resp_rdata !== 64'h0) begin
         n_bad++;
         $display("FAIL reset_rdata: got %h, required 0", resp_rdata);
      end
      n_cmp++;
      if ({icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask} !== '0) begin
         n_bad++;
         $display("FAIL reset_cmd: addr %h wdata %h, required 0", icb_cmd_addr, icb_cmd_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      clear_q();
   endtask

   task automatic test_single_write();
      int stall;
      clear_q();
      plan_q.push_back(mk_plan(0, 1, 64'hDEAD_BEEF_0000_1111, 1'b0));
      push_req(mk_req(1'b0, 32'h2000_0000, 64'hF, 8'hFF), stall);
      n_cmp++;
      if (icb_cmd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_cmd_early: icb_cmd_valid=%b at E, required 0", icb_cmd_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (icb_cmd_valid !== 1'b1 || icb_cmd_addr !== 32'h2000_0000 || icb_cmd_read !== 1'b0
          || icb_cmd_wdata !== 64'hF || icb_cmd_wmask !== 8'hFF) begin
         n_bad++;
         $display("FAIL wr_cmd: valid %b addr %h rd %b wdata %h mask %h, required 1 20000000 0 f ff",
                  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({resp_valid, resp_rdata, resp_err} !== {1'b1, 64'h0, 1'b0}) begin
         n_bad++;
         $display("FAIL wr_resp: valid %b rdata %h err %b, required 1 0 0",
                  resp_valid, resp_rdata, resp_err);
      end
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_pulse: resp_valid=%b one cycle later, required 0", resp_valid);
      end
      wait_idle();
      n_cmp++;
      if (got_q.size() != 1) begin
         n_bad++;
         $display("FAIL wr_count: %0d completions, required 1", got_q.size());
      end
   endtask

   task automatic test_read_stall();
      int stall;
      clear_q();
      plan_q.push_back(mk_plan(3, 0, 64'h0123_4567_89AB_CDEF, 1'b0));
      push_req(mk_req(1'b1, 32'h2000_0020, 64'h5555_AAAA_5555_AAAA, 8'h0F), stall);
      wait_idle();
      n_cmp++;
      if (got_q.size() != 1 || got_q[0] !== {64'h0123_4567_89AB_CDEF, 1'b0}) begin
         n_bad++;
         $display("FAIL rd_resp: %0d completions, first %h, required 1 / 0123456789abcdef err 0",
                  got_q.size(), got_q.size() > 0 ? got_q[0].rdata : 64'h0);
      end
      n_cmp++;
      if (seen_q.size() != 1 || seen_q[0].unstable !== 1'b0 || seen_q[0].cmd_cycles != 4
          || seen_q[0].req.addr !== 32'h2000_0020) begin
         n_bad++;
         $display("FAIL rd_stall: %0d cmds, unstable %b cycles %0d, required 1 cmd stable 4",
                  seen_q.size(), seen_q.size() > 0 ? seen_q[0].unstable : 1'b1,
                  seen_q.size() > 0 ? seen_q[0].cmd_cycles : -1);
      end
   endtask

   task automatic test_fifo_full();
      int   stall;
      req_t rq[6];
      clear_q();
      for (int i = 0; i < 6; i++) begin
         rq[i] = mk_req(1'b0, 32'h3000_0000 + 32'(i * 8), {$urandom, $urandom}, 8'hFF);
         plan_q.push_back(mk_plan(i == 0 ? 8 : 0, 0, 64'h0, 1'b0));
      end
      for (int i = 0; i < 5; i++) begin
         push_req(rq[i], stall);
         n_cmp++;
         if (stall != 0) begin
            n_bad++;
            $display("FAIL full_accept%0d: stalled %0d cycles, required 0", i, stall);
         end
      end
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL full_ready: req_ready=%b with 4 queued, required 0", req_ready);
      end
      push_req(rq[5], stall);
      n_cmp++;
      if (stall == 0 || got_q.size() != 1) begin
         n_bad++;
         $display("FAIL full_sixth: stall %0d, completions %0d, required >0 and 1",
                  stall, got_q.size());
      end
      wait_idle();
      n_cmp++;
      if (seen_q.size() != 6 || got_q.size() != 6) begin
         n_bad++;
         $display("FAIL full_count: cmds %0d resps %0d, required 6", seen_q.size(), got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (seen_q[i].req !== rq[i] || got_q[i].err !== 1'b0) begin
               n_bad++;
               $display("FAIL full_order%0d: addr %h err %b, required %h 0",
                        i, seen_q[i].req.addr, got_q[i].err, rq[i].addr);
            end
         end
      end
   endtask

   task automatic test_timeout();
      int   stall;
      req_t r0, r1, r2;
      clear_q();
      r0 = mk_req(1'b0, 32'h2000_0040, 64'h1, 8'h01);
      r1 = mk_req(1'b1, 32'h2000_0048, 64'h2, 8'h02);
      r2 = mk_req(1'b1, 32'h2000_0050, 64'h3, 8'h03);
      plan_q.push_back(mk_plan(TIMEOUT + 4, 0, 64'h0, 1'b0));
      plan_q.push_back(mk_plan(1, 2, 64'hCAFE_F00D_1234_5678, 1'b0));
      plan_q.push_back(mk_plan(0, TIMEOUT + 1, 64'h7777, 1'b0));
      push_req(r0, stall);
      push_req(r1, stall);
      push_req(r2, stall);
      wait_idle();
      n_cmp++;
      if (got_q.size() != 3 || seen_q.size() != 3) begin
         n_bad++;
         $display("FAIL to_count: resps %0d cmds %0d, required 3", got_q.size(), seen_q.size());
      end else begin
         n_cmp++;
         if (got_q[0] !== {64'h0, 1'b1} || seen_q[0].cmd_cycles != int'(TIMEOUT)) begin
            n_bad++;
            $display("FAIL to_cmd: rdata %h err %b cycles %0d, required 0 1 %0d",
                     got_q[0].rdata, got_q[0].err, seen_q[0].cmd_cycles, TIMEOUT);
         end
         n_cmp++;
         if (got_q[1] !== {64'hCAFE_F00D_1234_5678, 1'b0} || seen_q[1].req !== r1) begin
            n_bad++;
            $display("FAIL to_next: rdata %h addr %h, required cafef00d12345678 %h",
                     got_q[1].rdata, seen_q[1].req.addr, r1.addr);
         end
         n_cmp++;
         if (got_q[2] !== {64'h0, 1'b1} || seen_q[2].rsp_cycles != int'(TIMEOUT)) begin
            n_bad++;
            $display("FAIL to_rsp: rdata %h err %b cycles %0d, required 0 1 %0d",
                     got_q[2].rdata, got_q[2].err, seen_q[2].rsp_cycles, TIMEOUT);
         end
      end
   endtask

   task automatic test_rsp_err();
      int          stall;
      logic [63:0] d;
      clear_q();
      d = {$urandom, $urandom};
      plan_q.push_back(mk_plan(0, 2, d, 1'b1));
      push_req(mk_req(1'b1, 32'h2000_0018, 64'h0, 8'h00), stall);
      wait_idle();
      n_cmp++;
      if (got_q.size() != 1 || got_q[0] !== {d, 1'b1}) begin
         n_bad++;
         $display("FAIL rsp_err: %0d resps, first %h err %b, required %h err 1", got_q.size(),
                  got_q.size() > 0 ? got_q[0].rdata : 64'h0,
                  got_q.size() > 0 ? got_q[0].err : 1'b0, d);
      end
   endtask

   task automatic test_random();
      int    stall, ecmd, ersp;
      plan_t pl[$];
      req_t  r;
      plan_t p;
      got_t  g;
      clear_q();
      for (int i = 0; i < 40; i++) begin
         r = mk_req(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 8'($urandom));
         p = mk_plan(($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : $urandom_range(0, 4),
                     ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : $urandom_range(0, 4),
                     {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
         pl.push_back(p);
         plan_q.push_back(p);
         push_req(r, stall);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      n_cmp++;
      if (got_q.size() != 40 || seen_q.size() != 40 || exp_q.size() != 40) begin
         n_bad++;
         $display("FAIL rnd_count: resps %0d cmds %0d reqs %0d, required 40",
                  got_q.size(), seen_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < 40; i++) begin
            g    = model_resp(exp_q[i], pl[i]);
            ecmd = (pl[i].cmd_delay >= int'(TIMEOUT)) ? int'(TIMEOUT) : pl[i].cmd_delay + 1;
            ersp = (pl[i].cmd_delay >= int'(TIMEOUT)) ? 0 :
                   (pl[i].rsp_delay >= int'(TIMEOUT)) ? int'(TIMEOUT) : pl[i].rsp_delay + 1;
            n_cmp++;
            if (got_q[i] !== g) begin
               n_bad++;
               $display("FAIL rnd_resp%0d: rdata %h err %b, required %h %b",
                        i, got_q[i].rdata, got_q[i].err, g.rdata, g.err);
            end
            n_cmp++;
            if (seen_q[i].req !== exp_q[i] || seen_q[i].unstable !== 1'b0) begin
               n_bad++;
               $display("FAIL rnd_cmd%0d: cmd %h unstable %b, required %h stable",
                        i, seen_q[i].req, seen_q[i].unstable, exp_q[i]);
            end
            n_cmp++;
            if (seen_q[i].cmd_cycles != ecmd || seen_q[i].rsp_cycles != ersp) begin
               n_bad++;
               $display("FAIL rnd_phase%0d: cmd %0d rsp %0d cycles, required %0d %0d",
                        i, seen_q[i].cmd_cycles, seen_q[i].rsp_cycles, ecmd, ersp);
            end
         end
      end
      n_cmp++;
      if (hold_bad != 0) begin
         n_bad++;
         $display("FAIL resp_hold: %0d changes between pulses, required 0", hold_bad);
      end
   endtask

   task automatic test_reset_mid();
      int         stall;
      logic [5:0] ctrl;
      clear_q();
      plan_q.push_back(mk_plan(0, TIMEOUT + 8, 64'h0, 1'b0));
      plan_q.push_back(mk_plan(0, 0, 64'h0, 1'b0));
      plan_q.push_back(mk_plan(0, 0, 64'h0, 1'b0));
      for (int i = 0; i < 3; i++) begin
         push_req(mk_req(1'b1, 32'h4000_0000 + 32'(i * 8), 64'h0, 8'h00), stall);
      end
      n_cmp++;
      if (icb_rsp_ready !== 1'b1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_pre: rsp_ready %b busy %b, required 1 1", icb_rsp_ready, busy);
      end
      rst_n = 1'b0;
      #1;
      ctrl = {req_ready, icb_cmd_valid, icb_rsp_ready, resp_valid, resp_err, busy};
      n_cmp++;
      if (ctrl !== 6'b100000 || resp_rdata !== 64'h0) begin
         n_bad++;
         $display("FAIL mid_reset: ctrl %b rdata %h, required 100000 0", ctrl, resp_rdata);
      end
      n_cmp++;
      if ({icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask} !== '0) begin
         n_bad++;
         $display("FAIL mid_cmd: addr %h, required 0", icb_cmd_addr);
      end
      repeat (2) @(negedge clk);
      plan_q.delete();
      rst_n = 1'b1;
      repeat (2 * TIMEOUT) @(negedge clk);
      n_cmp++;
      if (got_q.size() != 0 || busy !== 1'b0 || icb_cmd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_after: %0d resps busy %b cmd_valid %b, required 0 0 0",
                  got_q.size(), busy, icb_cmd_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_stall();
      test_fifo_full();
      test_timeout();
      test_rsp_err();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
